// File: rtl/encryption_core.sv
// encryption_core -- iterative AES-128 encryption engine.
//
// One full AES round is executed per clock. The round key is expanded on the
// fly from the previous one, so only a single 128-bit key register is kept.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request, sampled only while idle
//   key_in   : 128-bit cipher key (byte 0 = bits [127:120], column-major)
//   data_in  : 128-bit plaintext, same byte order
//   busy     : high while rounds are being executed
//   done     : one-cycle strobe, ciphertext valid on data_out
//   data_out : ciphertext, held until the next block completes or reset
module encryption_core #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out
);

   generate
      if (NR != 10) begin : g_nr_unsupported
         $error("encryption_core: only NR=10 (AES-128) is supported");
      end
   endgenerate

   // S-box, row-major: entry 0 in the top byte.
   localparam logic [2047:0] SBOX_BITS = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   state_t       st;
   logic [3:0]   round;
   logic [127:0] state_reg;
   logic [127:0] rk_reg;
   logic [127:0] rk_next;
   logic [127:0] sr_out;
   logic [127:0] mc_out;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_BITS[2047 - 8 * int'(a) -: 8];
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
      return r;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
      return r;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
      {w0, w1, w2, w3} = rk;
      w4 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
      w5 = w1 ^ w4;
      w6 = w2 ^ w5;
      w7 = w3 ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign rk_next = key_expand(rk_reg, rcon(round));
   assign sr_out  = shift_rows(sub_bytes(state_reg));
   assign mc_out  = mix_columns(sr_out);

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         round     <= 4'd0;
         state_reg <= '0;
         rk_reg    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         data_out  <= '0;
      end else begin
         done <= 1'b0;
         case (st)
            S_IDLE: begin
               if (start) begin
                  state_reg <= data_in ^ key_in;
                  rk_reg    <= key_in;
                  round     <= 4'd1;
                  busy      <= 1'b1;
                  st        <= S_ROUND;
               end
            end
            S_ROUND: begin
               rk_reg <= rk_next;
               round  <= round + 4'd1;
               if (round == 4'(NR)) begin
                  // Final round skips MixColumns.
                  state_reg <= sr_out ^ rk_next;
                  data_out  <= sr_out ^ rk_next;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  st        <= S_DONE;
               end else begin
                  state_reg <= mc_out ^ rk_next;
               end
            end
            S_DONE: st <= S_IDLE;
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encryption_core.sv
// tb_encryption_core -- randomized scoreboard bench for encryption_core.
//
// A reference AES-128 (S-box derived from GF(2^8) inversion plus the affine
// map, key schedule as a 44-word array) predicts each accepted block. A model
// of request acceptance pushes predictions into a queue; a monitor on the
// falling edge pops and compares whenever the core strobes done, and also
// tracks busy/done/data_out cycle by cycle.
module tb_encryption_core;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] data_in;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]   sb [256];
   logic [127:0] exp_q [$];
   int           cnt = 0;
   logic [127:0] pend = '0;
   logic [127:0] dout_model = '0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   encryption_core #(.NR(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] x, inv;
      for (int v = 0; v < 256; v++) begin
         x = 8'(v);
         inv = 8'h00;
         if (v != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
         sb[v] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [31:0]  kw;
      logic [127:0] out;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) begin
         kw = w[i/4];
         s[i] = pt[127 - 8*i -: 8] ^ kw[31 - 8*(i%4) -: 8];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) t[r] = s[4*c + r];
               for (int r = 0; r < 4; r++)
                  s[4*c + r] = gmul(t[r], 8'h02) ^ gmul(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
            end
         end
         for (int i = 0; i < 16; i++) begin
            kw = w[4*rnd + i/4];
            s[i] = s[i] ^ kw[31 - 8*(i%4) -: 8];
         end
      end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Acceptance model: a request is taken only when no block is outstanding;
   // a block occupies 11 edges after its accept edge before the next can start.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            cnt = 0;
            dout_model = '0;
            exp_q.delete();
         end else if (cnt == 0) begin
            if (start) begin
               pend = aes_ref(key_in, data_in);
               exp_q.push_back(pend);
               cnt = 11;
            end
         end else begin
            cnt--;
            if (cnt == 1) dout_model = pend;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         chk_int("busy", int'(busy), int'(cnt >= 2));
         chk_int("done", int'(done), int'(cnt == 1));
         chk128("data_out_hold", data_out, dout_model);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected_done: got done=1, want no outstanding block");
            end else begin
               chk128("sb_dout", data_out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish by 300000, want finish");
      $fatal(1, "watchdog expired");
   end

   // Waits for done (bounded), checks latency from accept and the ciphertext,
   // then steps past the DONE cycle so the core is idle again.
   task automatic finish_block(input int e0, input logic [127:0] exp, input string name,
                               input bit scramble);
      int e;
      e = e0;
      while (!done && e < 40) begin
         if (scramble) begin
            key_in  = rand128();
            data_in = rand128();
         end
         @(posedge clk); #1;
         e++;
      end
      chk_int({name, "_latency"}, e, 11);
      chk128({name, "_dout"}, data_out, exp);
      @(posedge clk); #1;
   endtask

   task automatic accept(input logic [127:0] k, input logic [127:0] d);
      key_in  = k;
      data_in = d;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      int n_done;
      int last;
      int e;
      build_sbox();
      rst = 1'b1; start = 1'b0; key_in = '0; data_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_int("reset_busy", int'(busy), 0);
      chk_int("reset_done", int'(done), 0);
      chk128("reset_dout", data_out, '0);

      // Known-answer vector 1
      accept(K1, P1);
      finish_block(1, C1, "t1", 1'b0);

      // Vector 2 with state check after round 1
      accept(K2, P2);
      @(posedge clk); #1;
      chk128("t2_round1_state", dut.state_reg, R1);
      finish_block(2, C2, "t2", 1'b0);

      // All-zero vector, start pulsed mid-block must be ignored
      accept('0, '0);
      repeat (4) begin @(posedge clk); #1; end
      key_in = rand128(); data_in = rand128(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_int("t3_busy_mid", int'(busy), 1);
      finish_block(6, C3, "t3", 1'b0);

      // Inputs scrambled every cycle after accept
      accept(K1, P1);
      finish_block(1, C1, "t4", 1'b1);

      // Reset mid-block aborts it
      accept(K1, P1);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_int("t5_busy", int'(busy), 0);
      chk_int("t5_done", int'(done), 0);
      chk128("t5_dout", data_out, '0);
      n_done = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk_int("t5_no_done", n_done, 0);
      accept(K2, P2);
      finish_block(1, C2, "t5_after", 1'b0);

      // start held high: back-to-back blocks every 12 cycles
      key_in = K2; data_in = P2; start = 1'b1;
      last = -1; n_done = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 30) start = 1'b0;
         if (done) begin
            n_done++;
            chk128("t6_dout", data_out, C2);
            if (last >= 0) chk_int("t6_period", k - last, 12);
            last = k;
         end
      end
      chk_int("t6_count", n_done, 3);

      // Random blocks, checked by the scoreboard
      for (int n = 0; n < 10; n++) begin
         accept(rand128(), rand128());
         e = 1;
         while (!done && e < 40) begin @(posedge clk); #1; e++; end
         chk_int("rand_latency", e, 11);
         @(posedge clk); #1;
         repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      end

      repeat (5) @(posedge clk);
      #1;
      chk_int("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
